// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU load/store path: FSM states,
// word geometry and the address-error rule used by the data memory responder.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WORD_BYTES     = 4;
   localparam int MEM_DEPTH_LOG2 = 6;

   // A word access is legal only when word aligned and inside the array.
   function automatic logic addr_err(input logic [31:0] addr, input int depth_log2);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr % WORD_BYTES) != 32'd0;
      out_of_range = (addr >> (depth_log2 + 2)) != 32'd0;
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word RAM with write enable and registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module mem_array_sp #(
   parameter int DEPTH_LOG2 = 6,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem_reg [0:(1<<DEPTH_LOG2)-1];
   logic [WIDTH-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[addr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem_reg[addr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle data memory for the CPU load/store port: one word
// transaction at a time, programmable access latency, error on bad addresses.
module data_mem_responder
   import cpu_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_LOG2  = MEM_DEPTH_LOG2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] acc_cnt
);

   localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
   localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        req_ready_reg;
   logic        rsp_valid_reg;
   logic        rsp_err_reg;
   logic        rd_ok_reg;
   logic        busy_reg;
   logic [15:0] acc_cnt_reg;

   logic        accept;
   logic        commit;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_err;
   logic [31:0] ram_rdata;

   assign accept = (state_reg == IDLE) && req_valid && req_ready_reg;

   // With no wait cycles the commit happens on the acceptance edge itself,
   // so the request fields come straight from the port instead of the latch.
   assign c_we    = (state_reg == IDLE) ? req_we    : we_reg;
   assign c_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
   assign c_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
   assign c_err   = addr_err(c_addr, DEPTH_LOG2);

   assign commit = !rst &&
                   ((accept && !HAS_WAIT) ||
                    ((state_reg == WAIT) && (cnt_reg == 4'd0)));

   mem_array_sp #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (32)
   ) u_mem (
      .clk   (clk),
      .we    (commit && c_we && !c_err),
      .re    (commit && !c_we && !c_err),
      .addr  (c_addr[DEPTH_LOG2+1:2]),
      .wdata (c_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         we_reg        <= 1'b0;
         addr_reg      <= 32'd0;
         wdata_reg     <= 32'd0;
         req_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rd_ok_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         acc_cnt_reg   <= 16'd0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (accept) begin
                  we_reg        <= req_we;
                  addr_reg      <= req_addr;
                  wdata_reg     <= req_wdata;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  if (HAS_WAIT) begin
                     state_reg <= WAIT;
                     cnt_reg   <= WAIT_LOAD;
                  end else begin
                     state_reg     <= RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= c_err;
                     rd_ok_reg     <= !c_we && !c_err;
                  end
               end
            end
            WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg     <= RESP;
                  rsp_valid_reg <= 1'b1;
                  rsp_err_reg   <= c_err;
                  rd_ok_reg     <= !c_we && !c_err;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_reg     <= IDLE;
                  rsp_valid_reg <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  rd_ok_reg     <= 1'b0;
                  req_ready_reg <= 1'b1;
                  busy_reg      <= 1'b0;
                  acc_cnt_reg   <= acc_cnt_reg + 16'd1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               rsp_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   // RAM read register is not reset; the gate keeps stores/errors reading 0.
   assign rsp_rdata = rd_ok_reg ? ram_rdata : 32'd0;
   assign req_ready = req_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_err   = rsp_err_reg;
   assign busy      = busy_reg;
   assign acc_cnt   = acc_cnt_reg;

endmodule
